// File: rtl/hc_parity_rx.sv
// hc_parity_rx -- bit-serial UART-style frame receiver with XOR parity check.
//
// Receives start / DATA_W data bits (LSB first) / optional parity / stop
// frames on RXD, oversampled OVERSAMPLE times per bit and sampled mid-bit.
// The received word and its error flags are presented in parallel.
//
// Optional feature macro: HC_RX_PARITY_BIT_EN
//   defined     : frame carries a parity bit, checked against ODD_PARITY.
//   not defined : no parity bit in the frame, PERR tied to 0.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   synchronous reset, active-high
//   RXD    in   serial line, idles high, asynchronous to CLK
//   DOUT   out  last received data word (held until next VALID)
//   VALID  out  one-cycle pulse when a frame completes
//   PERR   out  parity error flag for the frame reported by VALID
//   FERR   out  framing error flag (stop bit sampled 0)
//   BUSY   out  high whenever the receiver is not idle

module hc_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int ODD_PARITY = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD,
    output logic [DATA_W-1:0] DOUT,
    output logic              VALID,
    output logic              PERR,
    output logic              FERR,
    output logic              BUSY
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_W);

    localparam logic [SCW-1:0] MID_CNT  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] LAST_CNT = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef HC_RX_PARITY_BIT_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Two-flop synchroniser; reset to the idle line level so a low RXD
    // during reset cannot look like a start bit afterwards.
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RXD;
            r_rxs     <= r_rx_meta;
        end
    end

    state_t            r_state;
    logic [SCW-1:0]    r_sample_cnt;
    logic [BCW-1:0]    r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_ferr;
    logic              r_busy;
`ifdef HC_RX_PARITY_BIT_EN
    logic              r_par_err;
    logic              r_perr;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_ferr       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef HC_RX_PARITY_BIT_EN
            r_par_err    <= 1'b0;
            r_perr       <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    if (r_sample_cnt == MID_CNT) begin
                        // Re-zero here so later samples land a full bit
                        // period apart, each at mid-bit.
                        r_sample_cnt <= '0;
                        if (r_rxs) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SCW'(1);
                    end
                end
                S_DATA: begin
                    if (r_sample_cnt == LAST_CNT) begin
                        r_sample_cnt <= '0;
                        r_shift      <= {r_rxs, r_shift[DATA_W-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef HC_RX_PARITY_BIT_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SCW'(1);
                    end
                end
`ifdef HC_RX_PARITY_BIT_EN
                S_PARITY: begin
                    if (r_sample_cnt == LAST_CNT) begin
                        r_sample_cnt <= '0;
                        r_par_err    <= ((^r_shift) ^ r_rxs) != (ODD_PARITY != 0);
                        r_state      <= S_STOP;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SCW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_sample_cnt == LAST_CNT) begin
                        r_sample_cnt <= '0;
                        r_valid      <= 1'b1;
                        r_dout       <= r_shift;
                        r_ferr       <= ~r_rxs;
`ifdef HC_RX_PARITY_BIT_EN
                        r_perr       <= r_par_err;
`endif
                        // Leaving at mid stop bit lets a start edge that
                        // directly follows the stop bit be caught.
                        r_busy       <= ~r_rxs;
                        r_state      <= r_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SCW'(1);
                    end
                end
                S_BREAK: begin
                    // Held-low line: wait for it to return high without
                    // looking for a new start bit.
                    if (r_rxs) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DOUT  = r_dout;
    assign VALID = r_valid;
    assign FERR  = r_ferr;
    assign BUSY  = r_busy;
`ifdef HC_RX_PARITY_BIT_EN
    assign PERR  = r_perr;
`else
    assign PERR  = 1'b0;
    // ODD_PARITY has no effect without a parity bit in the frame.
    wire w_unused_odd_parity = (ODD_PARITY != 0);
`endif

endmodule

// File: tb/tb_hc_parity_rx.sv
module tb_hc_parity_rx;

    localparam int OS = 16;
`ifdef HC_RX_PARITY_BIT_EN
    localparam int HAS_PAR = 1;
`else
    localparam int HAS_PAR = 0;
`endif
    localparam int FRAME_BITS = 10 + HAS_PAR;
    // Cycles from the RXD falling edge to VALID, including the synchroniser.
    localparam int LAT = OS / 2 + (8 + 1 + HAS_PAR) * OS + 1 + 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DOUT, DOUT_O;
    logic       VALID, PERR, FERR, BUSY;
    logic       VALID_O, PERR_O, FERR_O, BUSY_O;

    always #5 CLK = ~CLK;

    hc_parity_rx #(.DATA_W(8), .OVERSAMPLE(OS), .ODD_PARITY(0)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .DOUT(DOUT), .VALID(VALID),
        .PERR(PERR), .FERR(FERR), .BUSY(BUSY)
    );

    hc_parity_rx #(.DATA_W(8), .OVERSAMPLE(OS), .ODD_PARITY(1)) dut_odd (
        .CLK(CLK), .RST(RST), .RXD(RXD), .DOUT(DOUT_O), .VALID(VALID_O),
        .PERR(PERR_O), .FERR(FERR_O), .BUSY(BUSY_O)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic       perr_odd;
    } rec_t;

    rec_t recs[$];
    int   cyc = 0;
    int   n_odd_valid = 0;
    int   checks = 0;
    int   failures = 0;

    // Every cycle VALID is high becomes one record, so a stretched pulse
    // shows up as an extra frame.
    always @(negedge CLK) begin
        if (VALID)
            recs.push_back('{cyc, DOUT, PERR, FERR, PERR_O});
        if (VALID_O)
            n_odd_valid = n_odd_valid + 1;
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        tick(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int t0);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        if (HAS_PAR != 0)
            send_bit(p);
        send_bit(s);
    endtask

    int base;
    int t0, t1, t2;

    initial begin
        // Reset with a falling RXD edge inside it.
        RST = 1'b1;
        RXD = 1'b0;
        tick(3);
        check("rst_dout",  32'(DOUT),  32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_perr",  32'(PERR),  32'h0);
        check("rst_ferr",  32'(FERR),  32'h0);
        check("rst_busy",  32'(BUSY),  32'h0);
        RXD = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(20);
        check("post_rst_busy",  32'(BUSY), 32'h0);
        check("post_rst_nvalid", 32'(recs.size()), 32'h0);

        // 0xA5: four ones, p=0 correct even parity.
        base = recs.size();
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        tick(20);
        check("a5_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("a5_dout",    32'(recs[base].d),        32'hA5);
            check("a5_perr",    32'(recs[base].perr),     32'h0);
            check("a5_ferr",    32'(recs[base].ferr),     32'h0);
            check("a5_latency", 32'(recs[base].cyc - t0), 32'(LAT));
            check("a5_perr_odd", 32'(recs[base].perr_odd), 32'(HAS_PAR));
        end
        check("a5_busy", 32'(BUSY), 32'h0);

        // 0x01 with p=0: even parity violated, odd parity satisfied.
        base = recs.size();
        send_frame(8'h01, 1'b0, 1'b1, t0);
        tick(20);
        check("x01_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("x01_dout",     32'(recs[base].d),        32'h01);
            check("x01_perr",     32'(recs[base].perr),     32'(HAS_PAR));
            check("x01_ferr",     32'(recs[base].ferr),     32'h0);
            check("x01_perr_odd", 32'(recs[base].perr_odd), 32'h0);
        end

        // 0x3C with stop bit low, line held low for 40 bit times.
        base = recs.size();
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        tick(40 * OS);
        check("brk_busy_low", 32'(BUSY), 32'h1);
        check("brk_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("brk_dout", 32'(recs[base].d),    32'h3C);
            check("brk_ferr", 32'(recs[base].ferr), 32'h1);
            check("brk_perr", 32'(recs[base].perr), 32'h0);
        end
        RXD = 1'b1;
        tick(20);
        check("brk_busy_high", 32'(BUSY), 32'h0);
        check("brk_count_after", 32'(recs.size() - base), 32'd1);
        base = recs.size();
        send_frame(8'h55, 1'b0, 1'b1, t0);
        tick(20);
        check("x55_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("x55_dout", 32'(recs[base].d),    32'h55);
            check("x55_ferr", 32'(recs[base].ferr), 32'h0);
            check("x55_perr", 32'(recs[base].perr), 32'h0);
        end

        // 4-cycle glitch on the idle line.
        base = recs.size();
        RXD = 1'b0;
        tick(4);
        RXD = 1'b1;
        check("glitch_busy_hi", 32'(BUSY), 32'h1);
        tick(8);
        check("glitch_busy_lo", 32'(BUSY), 32'h0);
        tick(40);
        check("glitch_count", 32'(recs.size() - base), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        tick(20);
        check("x81_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("x81_dout", 32'(recs[base].d),    32'h81);
            check("x81_perr", 32'(recs[base].perr), 32'h0);
        end

        // Reset pulse during data bit 4 of a 0xFF frame.
        base = recs.size();
        RXD = 1'b0;
        tick(OS);
        RXD = 1'b1;
        tick(4 * OS + OS / 2);
        check("mid_busy_before", 32'(BUSY), 32'h1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("mid_rst_dout",  32'(DOUT),  32'h0);
        check("mid_rst_busy",  32'(BUSY),  32'h0);
        check("mid_rst_valid", 32'(VALID), 32'h0);
        check("mid_rst_ferr",  32'(FERR),  32'h0);
        check("mid_rst_perr",  32'(PERR),  32'h0);
        tick(200);
        check("mid_rst_count", 32'(recs.size() - base), 32'd0);
        send_frame(8'hFF, 1'b0, 1'b1, t0);
        tick(20);
        check("xff_count", 32'(recs.size() - base), 32'd1);
        if (recs.size() > base) begin
            check("xff_dout",     32'(recs[base].d),        32'hFF);
            check("xff_perr",     32'(recs[base].perr),     32'h0);
            check("xff_perr_odd", 32'(recs[base].perr_odd), 32'(HAS_PAR));
        end

        // Three back-to-back frames, no idle gap.
        base = recs.size();
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t1);
        send_frame(8'h5A, 1'b0, 1'b1, t2);
        tick(20);
        check("b2b_count", 32'(recs.size() - base), 32'd3);
        if (recs.size() >= base + 3) begin
            check("b2b_d0", 32'(recs[base].d),     32'h00);
            check("b2b_d1", 32'(recs[base + 1].d), 32'hFF);
            check("b2b_d2", 32'(recs[base + 2].d), 32'h5A);
            check("b2b_gap01", 32'(recs[base + 1].cyc - recs[base].cyc), 32'(FRAME_BITS * OS));
            check("b2b_gap12", 32'(recs[base + 2].cyc - recs[base + 1].cyc), 32'(FRAME_BITS * OS));
            check("b2b_perr", 32'({recs[base].perr, recs[base + 1].perr, recs[base + 2].perr}), 32'h0);
            check("b2b_latency0", 32'(recs[base].cyc - t0), 32'(LAT));
        end

        check("odd_valid_count", 32'(n_odd_valid), 32'(recs.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
